// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round sequencer and its datapath.
package aes_pkg;

    typedef enum logic [2:0] {
        NOOP            = 3'd0,
        AESENC          = 3'd1,
        AESENCLAST      = 3'd2,
        AESDEC          = 3'd3,
        AESDECLAST      = 3'd4,
        AESKEYGENASSIST = 3'd5,
        AESENCFULL      = 3'd6,
        AESDECFULL      = 3'd7
    } opcode;

    typedef enum logic {
        KEY128 = 1'b0,
        KEY256 = 1'b1
    } key_len_e;

    typedef logic [3:0][7:0] aes_32;

    localparam logic [3:0] NR_128        = 4'd10;
    localparam logic [3:0] NR_256        = 4'd14;
    localparam logic [7:0] RCON_FIRST    = 8'h01;
    localparam logic [7:0] RCON_LAST_128 = 8'h36;
    localparam logic [7:0] RCON_LAST_256 = 8'h40;

    function automatic logic is_full_op(input opcode op);
        return (op == AESENCFULL) || (op == AESDECFULL);
    endfunction

    function automatic logic is_dec_op(input opcode op);
        return (op == AESDEC) || (op == AESDECLAST) || (op == AESDECFULL);
    endfunction

endpackage

// File: rtl/aes_rcon_step.sv
// One step of the round-constant sequence in GF(2^8), forward for the
// cipher and backward for the inverse cipher.
module aes_rcon_step (
    input  logic [7:0] i_rcon,
    input  logic       i_dec,
    output logic [7:0] o_rcon
);

    always_comb begin
        o_rcon = 8'h00;
        if (i_dec) begin
            o_rcon = (i_rcon == 8'h1b) ? 8'h80 : {1'b0, i_rcon[7:1]};
        end else begin
            o_rcon = (i_rcon == 8'h80) ? 8'h1b : {i_rcon[6:0], 1'b0};
        end
    end

endmodule

// File: rtl/aes_seq.sv
// AES round sequencer: walks the aes_enc / key_gen / S-box datapath through
// single rounds, key-generation assists and full 10/14-round (de)ciphers.
module aes_seq
    import aes_pkg::*;
#(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start_i,
    input  opcode      opcode_i,
    input  key_len_e   key_len_i,
    input  logic       abort_i,
    output logic       full_enc_o,
    output logic       zero_rnd_o,
    output logic       key_sel_o,
    output logic       final_rnd_o,
    output logic       en_rnd_o,
    output logic       key_sub_o,
    output logic       en_key_o,
    output logic       gen_key_o,
    output logic       next_rnd_o,
    output logic       key_rot_o,
    output logic       dec_o,
    output logic [3:0] rnd_num_o,
    output aes_32      r_con_ctrl_o,
    output logic       cipher_ready_o,
    output logic       key_ready_o,
    output logic       err_o,
    output logic       busy_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SBOX   = 2'd1;
    localparam logic [1:0] S_ROUND  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;
    localparam logic       ALLOW_256 = (MAX_KEY_BITS != 128);

    logic [1:0] r_state;
    logic [3:0] r_rnd;
    logic [7:0] r_rcon;
    opcode      r_op;
    key_len_e   r_klen;
    logic       r_dec;
    logic       r_err;

    logic [1:0] w_state_nxt;
    logic [7:0] w_rcon_step;
    logic [7:0] w_rcon_load;
    logic [3:0] w_nr;
    logic       w_idle, w_sbox, w_round, w_finish;
    logic       w_full, w_keygen, w_last, w_single, w_final, w_key_rot;
    logic       w_launch, w_illegal, w_accept, w_abort;

    assign w_idle   = (r_state == S_IDLE);
    assign w_sbox   = (r_state == S_SBOX);
    assign w_round  = (r_state == S_ROUND);
    assign w_finish = (r_state == S_FINISH);

    assign w_full    = is_full_op(r_op);
    assign w_keygen  = (r_op == AESKEYGENASSIST);
    assign w_last    = (r_op == AESENCLAST) || (r_op == AESDECLAST);
    assign w_single  = (r_op == AESENC) || (r_op == AESDEC);
    assign w_nr      = (r_klen == KEY256) ? NR_256 : NR_128;
    assign w_final   = w_full && (r_rnd == w_nr);
    // AES-256 alternates RotWord+Rcon (even rounds) with SubWord-only (odd rounds)
    assign w_key_rot = (r_klen == KEY128) || !r_rnd[0];

    assign w_launch  = w_idle && start_i && (opcode_i != NOOP);
    assign w_illegal = !ALLOW_256 && (key_len_i == KEY256);
    assign w_accept  = w_launch && !w_illegal;
    assign w_abort   = abort_i && !w_idle;

    assign w_rcon_load = !is_dec_op(opcode_i) ? RCON_FIRST :
                         (key_len_i == KEY256) ? RCON_LAST_256 : RCON_LAST_128;

    aes_rcon_step u_rcon_step (
        .i_rcon (r_rcon),
        .i_dec  (r_dec),
        .o_rcon (w_rcon_step)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = (opcode_i == AESKEYGENASSIST) ? S_ROUND : S_SBOX;
            S_SBOX:   w_state_nxt = S_ROUND;
            S_ROUND:  w_state_nxt = (w_full && !w_final) ? S_SBOX : S_FINISH;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (w_abort) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
            r_rnd   <= 4'd0;
            r_rcon  <= RCON_FIRST;
            r_op    <= NOOP;
            r_klen  <= KEY128;
            r_dec   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_launch && w_illegal;
            if (w_abort) begin
                r_rnd  <= 4'd0;
                r_rcon <= RCON_FIRST;
            end else if (w_accept) begin
                r_op   <= opcode_i;
                r_klen <= key_len_i;
                r_dec  <= is_dec_op(opcode_i);
                if (is_full_op(opcode_i)) begin
                    r_rnd  <= 4'd0;
                    r_rcon <= w_rcon_load;
                end
            end else if (w_sbox && w_full) begin
                r_rnd <= r_rnd + 4'd1;
            end else if (w_round && w_full && !w_final && w_key_rot) begin
                r_rcon <= w_rcon_step;
            end
        end
    end

    // IDLE holds the datapath in its default load/enable configuration
    assign full_enc_o  = w_idle || (w_round && ((w_full && !w_final) || w_single));
    assign final_rnd_o = w_idle || (w_round && (w_final || w_last));
    assign en_rnd_o    = w_idle || (w_round && !w_keygen);
    assign en_key_o    = w_idle || w_sbox;
    assign zero_rnd_o  = w_sbox && w_full && (r_rnd == 4'd0);
    assign key_sel_o   = w_round && w_full;
    assign key_sub_o   = w_sbox || (w_round && w_keygen);
    assign gen_key_o   = w_round && (w_keygen || w_full);
    assign next_rnd_o  = w_round && w_full && !w_final;
    assign key_rot_o   = !w_idle && w_key_rot;
    assign dec_o       = r_dec;
    assign rnd_num_o   = r_rnd;
    assign r_con_ctrl_o = {r_rcon, 24'h000000};

    assign cipher_ready_o = w_finish && !w_keygen && !abort_i;
    assign key_ready_o    = w_finish && w_keygen && !abort_i;
    assign err_o          = r_err;
    assign busy_o         = w_sbox || w_round || w_accept;

endmodule

// File: tb/tb_aes_seq.sv
// Scoreboard bench for aes_seq: full/single/keygen runs, abort, error and reset.
module tb_aes_seq;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic start_i = 1'b0;
    opcode opcode_i = NOOP;
    key_len_e key_len_i = KEY128;
    logic abort_i = 1'b0;
    logic full_enc_o, zero_rnd_o, key_sel_o, final_rnd_o, en_rnd_o;
    logic key_sub_o, en_key_o, gen_key_o, next_rnd_o, key_rot_o, dec_o;
    logic [3:0] rnd_num_o;
    aes_32 r_con_ctrl_o;
    logic cipher_ready_o, key_ready_o, err_o, busy_o;

    logic start2 = 1'b0;
    opcode op2 = NOOP;
    key_len_e kl2 = KEY128;
    logic abort2 = 1'b0;
    logic full_enc2, zero_rnd2, key_sel2, final_rnd2, en_rnd2;
    logic key_sub2, en_key2, gen_key2, next_rnd2, key_rot2, dec2;
    logic [3:0] rnd2;
    aes_32 rcon2;
    logic cready2, kready2, err2, busy2;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic is_key;
        int   lat;
    } exp_t;
    exp_t sb_q[$];

    logic [7:0] rc_tab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    always #5 clk = ~clk;

    aes_seq #(.MAX_KEY_BITS(256)) dut (
        .clk(clk), .nrst(nrst), .start_i(start_i), .opcode_i(opcode_i),
        .key_len_i(key_len_i), .abort_i(abort_i),
        .full_enc_o(full_enc_o), .zero_rnd_o(zero_rnd_o), .key_sel_o(key_sel_o),
        .final_rnd_o(final_rnd_o), .en_rnd_o(en_rnd_o), .key_sub_o(key_sub_o),
        .en_key_o(en_key_o), .gen_key_o(gen_key_o), .next_rnd_o(next_rnd_o),
        .key_rot_o(key_rot_o), .dec_o(dec_o), .rnd_num_o(rnd_num_o),
        .r_con_ctrl_o(r_con_ctrl_o), .cipher_ready_o(cipher_ready_o),
        .key_ready_o(key_ready_o), .err_o(err_o), .busy_o(busy_o)
    );

    aes_seq #(.MAX_KEY_BITS(128)) dut128 (
        .clk(clk), .nrst(nrst), .start_i(start2), .opcode_i(op2),
        .key_len_i(kl2), .abort_i(abort2),
        .full_enc_o(full_enc2), .zero_rnd_o(zero_rnd2), .key_sel_o(key_sel2),
        .final_rnd_o(final_rnd2), .en_rnd_o(en_rnd2), .key_sub_o(key_sub2),
        .en_key_o(en_key2), .gen_key_o(gen_key2), .next_rnd_o(next_rnd2),
        .key_rot_o(key_rot2), .dec_o(dec2), .rnd_num_o(rnd2),
        .r_con_ctrl_o(rcon2), .cipher_ready_o(cready2),
        .key_ready_o(kready2), .err_o(err2), .busy_o(busy2)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_rcon(input logic dec, input logic k256, input int r);
        int idx;
        if (!k256) idx = dec ? 10 - r : r - 1;
        else       idx = dec ? 6 - (r - 1) / 2 : (r - 1) / 2;
        return rc_tab[idx];
    endfunction

    task automatic check_reset(input string tag);
        chk_eq({tag, "_rnd"}, rnd_num_o, 0);
        chk_eq({tag, "_rcon"}, r_con_ctrl_o, 32'h01000000);
        chk_eq({tag, "_ready"}, {cipher_ready_o, key_ready_o, err_o, busy_o}, 4'b0000);
        chk_eq({tag, "_strobes_hi"}, {en_rnd_o, en_key_o, full_enc_o, final_rnd_o}, 4'b1111);
        chk_eq({tag, "_strobes_lo"}, {zero_rnd_o, key_sel_o, key_sub_o, gen_key_o,
                                      next_rnd_o, key_rot_o, dec_o}, 7'b0);
    endtask

    // Launch one operation from IDLE at the current falling edge and follow it
    // cycle by cycle; returns at the falling edge of the first IDLE cycle.
    task automatic run_op(input opcode op, input key_len_e kl, input int abort_cyc, input int stray_cyc);
        exp_t e, got_e;
        int nr, end_c, c, r, ready_c;
        logic seen, rdy, full, k256, dec;
        full = (op == AESENCFULL) || (op == AESDECFULL);
        k256 = (kl == KEY256);
        dec  = (op == AESDEC) || (op == AESDECLAST) || (op == AESDECFULL);
        nr   = k256 ? 14 : 10;
        e.is_key = (op == AESKEYGENASSIST);
        e.lat    = full ? 2 * nr + 1 : (e.is_key ? 2 : 3);
        if (abort_cyc == 0) sb_q.push_back(e);
        end_c = (abort_cyc == 0) ? e.lat + 1 : abort_cyc + 25;
        seen = 1'b0;
        ready_c = 0;
        start_i = 1'b1;
        opcode_i = op;
        key_len_i = kl;
        @(negedge clk);
        c = 1;
        while (c <= end_c) begin
            rdy = cipher_ready_o | key_ready_o;
            if (sb_q.size() == 0) begin
                chk_eq("no_ready", rdy, 0);
            end else if (rdy) begin
                got_e = sb_q.pop_front();
                chk_eq("ready_latency", c, got_e.lat);
                chk_eq("ready_kind", key_ready_o, got_e.is_key);
                seen = 1'b1;
                ready_c = c;
            end
            if (c == 1) chk_eq("busy_run", busy_o, 1);
            if (c == 1) chk_eq("no_err", err_o, 0);
            if (abort_cyc == 0 && c == e.lat) chk_eq("busy_finish", busy_o, 0);
            if (abort_cyc == 0 && c == e.lat + 1) chk_eq("ready_width", rdy, 0);
            if (op == AESDECLAST && c == 2) begin
                chk_eq("declast_full_enc", full_enc_o, 0);
                chk_eq("declast_dec", dec_o, 1);
            end
            if (full && (c % 2 == 0) && c <= 2 * nr && (abort_cyc == 0 || c <= abort_cyc)) begin
                r = c / 2;
                chk_eq("rnd_num", rnd_num_o, r);
                chk_eq("rcon", r_con_ctrl_o, {exp_rcon(dec, k256, r), 24'h0});
                chk_eq("final_rnd", final_rnd_o, (r == nr));
                chk_eq("key_rot", key_rot_o, (!k256 || (r % 2 == 0)));
                chk_eq("dec", dec_o, dec);
            end
            if (abort_cyc != 0 && c == abort_cyc + 1) begin
                chk_eq("abort_rnd", rnd_num_o, 0);
                chk_eq("abort_rcon", r_con_ctrl_o, 32'h01000000);
                chk_eq("abort_busy", busy_o, 0);
            end
            abort_i = (c == abort_cyc);
            start_i = (c == stray_cyc);
            if (c == stray_cyc) opcode_i = AESKEYGENASSIST;
            if (c == end_c) break;
            @(negedge clk);
            c++;
        end
        if (abort_cyc == 0) begin
            chk_eq("ready_seen", seen, 1);
            if (!seen && sb_q.size() != 0) void'(sb_q.pop_front());
        end
        $display("txn op=%s klen=%s abort_at=%0d ready_cycle=%0d", op.name(), kl.name(), abort_cyc, ready_c);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1 check_reset("rst_async");
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check_reset("rst");

        run_op(AESENCFULL, KEY128, 0, 5);
        run_op(AESENCFULL, KEY256, 0, 0);
        run_op(AESDECFULL, KEY128, 0, 0);
        run_op(AESDECFULL, KEY256, 0, 0);
        run_op(AESKEYGENASSIST, KEY128, 0, 0);
        run_op(AESDECLAST, KEY128, 0, 0);
        run_op(AESENC, KEY256, 0, 0);
        run_op(AESENCFULL, KEY128, 10, 0);

        // NOOP start leaves the sequencer idle
        start_i = 1'b1;
        opcode_i = NOOP;
        #1 chk_eq("noop_busy0", busy_o, 0);
        @(negedge clk);
        start_i = 1'b0;
        chk_eq("noop_busy1", busy_o, 0);
        chk_eq("noop_err", err_o, 0);
        $display("txn op=NOOP");

        // Illegal key length on a 128-bit-only instance
        start2 = 1'b1;
        op2 = AESENCFULL;
        kl2 = KEY256;
        #1 chk_eq("illegal_busy0", busy2, 0);
        @(negedge clk);
        start2 = 1'b0;
        chk_eq("illegal_err1", err2, 1);
        chk_eq("illegal_busy1", busy2, 0);
        @(negedge clk);
        chk_eq("illegal_err_width", err2, 0);
        chk_eq("illegal_busy2", busy2, 0);
        chk_eq("illegal_ready", {cready2, kready2}, 2'b00);
        $display("txn dut128 op=AESENCFULL klen=KEY256 err");

        // Asynchronous reset in the middle of a full cipher
        start_i = 1'b1;
        opcode_i = AESENCFULL;
        key_len_i = KEY128;
        @(negedge clk);
        start_i = 1'b0;
        repeat (6) @(negedge clk);
        nrst = 1'b0;
        #1 check_reset("midrst_async");
        @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < 25; i++) begin
            chk_eq("midrst_no_ready", cipher_ready_o | key_ready_o, 0);
            @(negedge clk);
        end
        check_reset("midrst_after");
        $display("txn op=AESENCFULL klen=KEY128 reset_mid_run");

        chk_eq("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
